// File: rtl/datapath_fsm.sv
// Control FSM for the 16-bit datapath: latches and decodes an instruction,
// then sequences register-file, ALU and status controls one state per cycle.
module datapath_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic [15:0] datapath_in,
  output logic [2:0]  writenum,
  output logic [2:0]  readnum,
  output logic        write,
  output logic        vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WR_REG,
    S_WR_IMM
  } state_t;

  typedef enum logic [2:0] {
    I_MOV_IMM,
    I_MOV_REG,
    I_ADD,
    I_CMP,
    I_AND,
    I_MVN,
    I_ILLEGAL
  } instr_t;

  logic [15:0] ir;
  state_t      state;
  state_t      state_next;
  instr_t      instr;

  logic [2:0]  rn;
  logic [2:0]  rd;
  logic [2:0]  rm;

  assign rn = ir[10:8];
  assign rd = ir[7:5];
  assign rm = ir[2:0];

  assign datapath_in = {{8{ir[7]}}, ir[7:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir <= '0;
    end else if (load) begin
      ir <= in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_WAIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    instr = I_ILLEGAL;
    case ({ir[15:13], ir[12:11]})
      5'b110_10: instr = I_MOV_IMM;
      5'b110_00: instr = I_MOV_REG;
      5'b101_00: instr = I_ADD;
      5'b101_01: instr = I_CMP;
      5'b101_10: instr = I_AND;
      5'b101_11: instr = I_MVN;
      default:   instr = I_ILLEGAL;
    endcase
  end

  always_comb begin
    state_next = state;
    w          = 1'b0;
    writenum   = '0;
    readnum    = '0;
    write      = 1'b0;
    vsel       = 1'b0;
    loada      = 1'b0;
    loadb      = 1'b0;
    loadc      = 1'b0;
    loads      = 1'b0;
    asel       = 1'b0;
    bsel       = 1'b1;
    // shift/ALUop only matter when C or status is latched, so they follow IR everywhere
    shift      = ir[4:3];
    case (instr)
      I_CMP:   ALUop = 2'b01;
      I_AND:   ALUop = 2'b10;
      I_MVN:   ALUop = 2'b11;
      default: ALUop = 2'b00;
    endcase

    case (state)
      S_WAIT: begin
        w = 1'b1;
        if (s) begin
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        case (instr)
          I_MOV_IMM:               state_next = S_WR_IMM;
          I_ADD, I_CMP, I_AND:     state_next = S_GET_A;
          I_MOV_REG, I_MVN:        state_next = S_GET_B;
          default:                 state_next = S_WAIT;
        endcase
      end
      S_GET_A: begin
        readnum    = rn;
        loada      = 1'b1;
        state_next = S_GET_B;
      end
      S_GET_B: begin
        readnum    = rm;
        loadb      = 1'b1;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        if (instr == I_CMP) begin
          loads      = 1'b1;
          state_next = S_WAIT;
        end else begin
          loadc      = 1'b1;
          asel       = (instr == I_MOV_REG);
          state_next = S_WR_REG;
        end
      end
      S_WR_REG: begin
        writenum   = rd;
        write      = 1'b1;
        state_next = S_WAIT;
      end
      S_WR_IMM: begin
        writenum   = rn;
        vsel       = 1'b1;
        write      = 1'b1;
        state_next = S_WAIT;
      end
      default: begin
        state_next = S_WAIT;
      end
    endcase
  end

endmodule

// File: tb/tb_datapath_fsm.sv
// Scoreboard bench for datapath_fsm: per-cycle expected control vectors are
// queued when an instruction starts and popped by a negedge monitor.
module tb_datapath_fsm;

  logic        clk;
  logic        reset;
  logic        s;
  logic        load;
  logic [15:0] in;
  logic        w;
  logic [15:0] datapath_in;
  logic [2:0]  writenum;
  logic [2:0]  readnum;
  logic        write;
  logic        vsel;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;

  datapath_fsm dut (
    .clk         (clk),
    .reset       (reset),
    .s           (s),
    .load        (load),
    .in          (in),
    .w           (w),
    .datapath_in (datapath_in),
    .writenum    (writenum),
    .readnum     (readnum),
    .write       (write),
    .vsel        (vsel),
    .loada       (loada),
    .loadb       (loadb),
    .loadc       (loadc),
    .loads       (loads),
    .asel        (asel),
    .bsel        (bsel),
    .shift       (shift),
    .ALUop       (ALUop)
  );

  typedef struct packed {
    logic        w;
    logic        write;
    logic        vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [2:0]  writenum;
    logic [2:0]  readnum;
    logic [1:0]  shift;
    logic [1:0]  alu;
    logic [15:0] dp;
  } ctl_t;

  typedef struct {
    string tag;
    ctl_t  c;
    bit    sa;
  } exp_t;

  exp_t  q[$];
  exp_t  stage[$];
  int    checks = 0;
  int    errors = 0;
  string cur_name = "none";

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(string tag, logic w_, logic wr, logic vs, logic la, logic lb,
                              logic lc, logic ls, logic as, logic [2:0] wn, logic [2:0] rn,
                              logic [1:0] sh, logic [1:0] alu, logic [15:0] dp, bit sa);
    exp_t e;
    e.tag        = tag;
    e.c.w        = w_;
    e.c.write    = wr;
    e.c.vsel     = vs;
    e.c.loada    = la;
    e.c.loadb    = lb;
    e.c.loadc    = lc;
    e.c.loads    = ls;
    e.c.asel     = as;
    e.c.bsel     = 1'b1;
    e.c.writenum = wn;
    e.c.readnum  = rn;
    e.c.shift    = sh;
    e.c.alu      = alu;
    e.c.dp       = dp;
    e.sa         = sa;
    return e;
  endfunction

  function automatic exp_t st_wait(logic [15:0] dp);
    return mk("WAIT", 1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 2'd0, 2'd0, dp, 0);
  endfunction
  function automatic exp_t st_dec(logic [15:0] dp);
    return mk("DECODE", 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 2'd0, 2'd0, dp, 0);
  endfunction
  function automatic exp_t st_geta(logic [2:0] rn, logic [15:0] dp);
    return mk("GET_A", 0, 0, 0, 1, 0, 0, 0, 0, 3'd0, rn, 2'd0, 2'd0, dp, 0);
  endfunction
  function automatic exp_t st_getb(logic [2:0] rm, logic [15:0] dp);
    return mk("GET_B", 0, 0, 0, 0, 1, 0, 0, 0, 3'd0, rm, 2'd0, 2'd0, dp, 0);
  endfunction
  function automatic exp_t st_exec(logic [1:0] sh, logic [1:0] alu, logic lc, logic ls,
                                   logic as, logic [15:0] dp);
    return mk("EXEC", 0, 0, 0, 0, 0, lc, ls, as, 3'd0, 3'd0, sh, alu, dp, 1);
  endfunction
  function automatic exp_t st_wrreg(logic [2:0] rd, logic [15:0] dp);
    return mk("WR_REG", 0, 1, 0, 0, 0, 0, 0, 0, rd, 3'd0, 2'd0, 2'd0, dp, 0);
  endfunction
  function automatic exp_t st_wrimm(logic [2:0] rn, logic [15:0] dp);
    return mk("WR_IMM", 0, 1, 1, 0, 0, 0, 0, 0, rn, 3'd0, 2'd0, 2'd0, dp, 0);
  endfunction

  task automatic compare(input exp_t e);
    ctl_t a;
    ctl_t x;
    a.w        = w;
    a.write    = write;
    a.vsel     = vsel;
    a.loada    = loada;
    a.loadb    = loadb;
    a.loadc    = loadc;
    a.loads    = loads;
    a.asel     = asel;
    a.bsel     = bsel;
    a.writenum = writenum;
    a.readnum  = readnum;
    a.shift    = shift;
    a.alu      = ALUop;
    a.dp       = datapath_in;
    x = e.c;
    if (!e.sa) begin
      a.shift = '0;
      a.alu   = '0;
      x.shift = '0;
      x.alu   = '0;
    end
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s [%s] t=%0t got %h required %h (w,wr,vsel,la,lb,lc,ls,asel,bsel,wn,rn,sh,alu,dp)",
               e.tag, cur_name, $time, a, x);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      compare(q.pop_front());
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 64) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout [%s] got %0d pending required 0", cur_name, q.size());
      q.delete();
    end
  endtask

  task automatic run(input string name, input logic [15:0] instr, input bit same_cycle,
                     input bit hold_s);
    @(posedge clk);
    #1;
    cur_name = name;
    load = 1'b1;
    in   = instr;
    if (same_cycle) s = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    if (!same_cycle) begin
      s = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!hold_s) s = 1'b0;
    while (stage.size() != 0) q.push_back(stage.pop_front());
    if (hold_s) begin
      repeat (3) @(posedge clk);
      #1;
      s = 1'b0;
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog [%s] got no finish required finish", cur_name);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    s     = 1'b0;
    load  = 1'b0;
    in    = 16'h0000;

    // asynchronous reset with clk still low
    #1 reset = 1'b1;
    #1 compare(mk("RESET_ASYNC", 1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 2'd0, 2'd0, 16'h0000, 0));
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    compare(st_wait(16'h0000));

    // MOV R0,#7
    stage.push_back(st_dec(16'h0007));
    stage.push_back(st_wrimm(3'd0, 16'h0007));
    stage.push_back(st_wait(16'h0007));
    run("MOV R0,#7", 16'hD007, 0, 0);

    // MOV R1,#2
    stage.push_back(st_dec(16'h0002));
    stage.push_back(st_wrimm(3'd1, 16'h0002));
    stage.push_back(st_wait(16'h0002));
    run("MOV R1,#2", 16'hD102, 0, 0);

    // MOV R3,#-1
    stage.push_back(st_dec(16'hFFFF));
    stage.push_back(st_wrimm(3'd3, 16'hFFFF));
    stage.push_back(st_wait(16'hFFFF));
    run("MOV R3,#-1", 16'hD3FF, 0, 0);

    // ADD R2,R1,R0,LSL#1
    stage.push_back(st_dec(16'h0048));
    stage.push_back(st_geta(3'd1, 16'h0048));
    stage.push_back(st_getb(3'd0, 16'h0048));
    stage.push_back(st_exec(2'b01, 2'b00, 1, 0, 0, 16'h0048));
    stage.push_back(st_wrreg(3'd2, 16'h0048));
    stage.push_back(st_wait(16'h0048));
    run("ADD R2,R1,R0,LSL#1", 16'hA148, 0, 0);

    // CMP R0,R0
    stage.push_back(st_dec(16'h0000));
    stage.push_back(st_geta(3'd0, 16'h0000));
    stage.push_back(st_getb(3'd0, 16'h0000));
    stage.push_back(st_exec(2'b00, 2'b01, 0, 1, 0, 16'h0000));
    stage.push_back(st_wait(16'h0000));
    run("CMP R0,R0", 16'hA800, 0, 0);

    // MOV R2,R0
    stage.push_back(st_dec(16'h0040));
    stage.push_back(st_getb(3'd0, 16'h0040));
    stage.push_back(st_exec(2'b00, 2'b00, 1, 0, 1, 16'h0040));
    stage.push_back(st_wrreg(3'd2, 16'h0040));
    stage.push_back(st_wait(16'h0040));
    run("MOV R2,R0", 16'hC040, 0, 0);

    // MVN R3,R0
    stage.push_back(st_dec(16'h0060));
    stage.push_back(st_getb(3'd0, 16'h0060));
    stage.push_back(st_exec(2'b00, 2'b11, 1, 0, 0, 16'h0060));
    stage.push_back(st_wrreg(3'd3, 16'h0060));
    stage.push_back(st_wait(16'h0060));
    run("MVN R3,R0", 16'hB860, 0, 0);

    // AND R5,R2,R3,ASR with load and s in the same WAIT cycle
    stage.push_back(st_dec(16'hFFB3));
    stage.push_back(st_geta(3'd2, 16'hFFB3));
    stage.push_back(st_getb(3'd3, 16'hFFB3));
    stage.push_back(st_exec(2'b10, 2'b10, 1, 0, 0, 16'hFFB3));
    stage.push_back(st_wrreg(3'd5, 16'hFFB3));
    stage.push_back(st_wait(16'hFFB3));
    run("AND R5,R2,R3 same-cycle", 16'hB2B3, 1, 0);

    // illegal opcode and illegal op
    stage.push_back(st_dec(16'h0000));
    stage.push_back(st_wait(16'h0000));
    run("ILLEGAL 0xE000", 16'hE000, 0, 0);
    stage.push_back(st_dec(16'h0000));
    stage.push_back(st_wait(16'h0000));
    run("ILLEGAL 0xC800", 16'hC800, 0, 0);

    // s held high: WAIT lasts one cycle, then the same instruction restarts
    stage.push_back(st_dec(16'h0007));
    stage.push_back(st_wrimm(3'd0, 16'h0007));
    stage.push_back(st_wait(16'h0007));
    stage.push_back(st_dec(16'h0007));
    stage.push_back(st_wrimm(3'd0, 16'h0007));
    stage.push_back(st_wait(16'h0007));
    run("MOV R0,#7 s held", 16'hD007, 0, 1);

    // reset during GET_B of an ADD
    stage.push_back(st_dec(16'h0048));
    stage.push_back(st_geta(3'd1, 16'h0048));
    stage.push_back(st_getb(3'd0, 16'h0048));
    run("ADD reset mid", 16'hA148, 0, 0);
    reset = 1'b1;
    #1 compare(mk("RESET_MID", 1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 2'd0, 2'd0, 16'h0000, 0));
    @(negedge clk);
    compare(mk("RESET_HOLD", 1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 2'd0, 2'd0, 16'h0000, 0));
    #1 reset = 1'b0;
    @(negedge clk);
    compare(mk("RESET_AFTER", 1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 2'd0, 2'd0, 16'h0000, 0));

    stage.push_back(st_dec(16'hFFFF));
    stage.push_back(st_wrimm(3'd3, 16'hFFFF));
    stage.push_back(st_wait(16'hFFFF));
    run("MOV R3,#-1 after reset", 16'hD3FF, 0, 0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_fsm.md
# datapath_fsm

Control unit that sits directly upstream of the datapath. It latches a 16-bit instruction, decodes it, and sequences every datapath control signal over several cycles. It also drives `datapath_in` with the sign-extended immediate. It handles register/immediate MOV, ADD, CMP, AND and MVN, and signals completion with `w`.

## Interface

Parameters:
- none (widths fixed: 16-bit data, 8 registers, 3-bit register numbers)

Ports (`clk` and `reset` come first):
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `s` in 1: start; sampled only in WAIT.
- `load` in 1: when 1, latches `in` into the instruction register (IR) on the rising edge, in any state.
- `in` in 16: instruction word.
- `w` out 1: 1 only in WAIT (idle, ready for `s`).
- `datapath_in` out 16: `{ {8{IR[7]}}, IR[7:0] }`, sign-extended imm8; valid at all times.
- `writenum` out 3: destination register number.
- `readnum` out 3: source register number.
- `write` out 1: register-file write enable.
- `vsel` out 1: 1 writes `datapath_in`; 0 writes register C.
- `loada`, `loadb`, `loadc`, `loads` out 1 each: load enables for registers A, B, C and status.
- `asel` out 1: 0 selects A; 1 selects 16'b0.
- `bsel` out 1: 1 selects shifted B (always driven 1).
- `shift` out 2: copy of IR[4:3]; 01 = left shift by 1.
- `ALUop` out 2: 00 ADD, 01 SUB/CMP, 10 AND, 11 NOT B.

## Operation

Decode fields:
- opcode = IR[15:13]
- op = IR[12:11]
- Rn = IR[10:8]
- Rd = IR[7:5]
- sh = IR[4:3]
- Rm = IR[2:0]

Instructions:
- 110/10 MOV Rn,#imm8
- 110/00 MOV Rd,Rm{,sh}
- 101/00 ADD Rd,Rn,Rm{,sh}
- 101/01 CMP Rn,Rm{,sh}
- 101/10 AND Rd,Rn,Rm{,sh}
- 101/11 MVN Rd,Rm{,sh}

Any other opcode/op combination is illegal.

States: WAIT, DECODE, GET_A, GET_B, EXEC, WR_REG, WR_IMM. Outputs are Moore: a function of the state and IR only. Every control not listed for a state is 0; `bsel` = 1 in every state.
- WAIT: `w` = 1. If `s` = 1, go to DECODE; otherwise stay.
- DECODE: no controls asserted. Next state:
  - MOV imm goes to WR_IMM.
  - ADD, CMP and AND go to GET_A.
  - MOV reg and MVN go to GET_B.
  - Illegal goes to WAIT, with no writes.
- GET_A: `readnum` = Rn, `loada` = 1. Next state GET_B.
- GET_B: `readnum` = Rm, `loadb` = 1. Next state EXEC.
- EXEC: `shift` = sh, `loadc` = 1, `ALUop` per the instruction:
  - MOV reg uses ADD with `asel` = 1.
  - CMP uses 01 with `loads` = 1 and `loadc` = 0.
  - Next state is WAIT for CMP, WR_REG otherwise.
- WR_REG: `writenum` = Rd, `vsel` = 0, `write` = 1. Next state WAIT.
- WR_IMM: `writenum` = Rn, `vsel` = 1, `write` = 1. Next state WAIT.

`readnum`/`writenum` hold 0 in states that do not use them. `shift`/`ALUop` hold IR-derived values in every state, because they only affect latched results in EXEC.

## Timing

Reset:
- Takes effect immediately, without waiting for `clk`.
- State goes to WAIT and IR to 0, so `w` = 1, all enables and `write` are 0, and `datapath_in` = 0.
- Reset mid-instruction aborts it with no further writes; a write already clocked stays.

Latency, counted in rising edges from the edge that samples `s` = 1 to the edge after which `w` = 1 again:
- MOV imm: 3
- MOV reg / MVN: 5
- ADD / AND: 6
- CMP: 5
- Illegal: 2

Other timing rules:
- Each state lasts exactly one cycle. A control asserted in state X acts at the edge that leaves X.
- `load` during execution changes IR, and therefore the decode of later states; the program must not do this. If it happens, the new IR is used from the next cycle.
- `s` outside WAIT is ignored.
- `s` held high across an instruction starts the next instruction the cycle after returning to WAIT.
- `load` and `s` in the same WAIT cycle: DECODE sees the newly loaded IR.

## Test plan

Each scenario checks the exact control signals in each state, plus the final register values when paired with the datapath.
- Reset: pulse `reset` with `clk` held low → `w` = 1, all enables 0, and `datapath_in` = 0x0000 immediately.
- MOV immediates:
  - Load 0xD007 then pulse `s` → WR_IMM drives `writenum` = 0, `vsel` = 1, `write` = 1, `datapath_in` = 0x0007; `w` returns after 3 edges.
  - Load 0xD3FF → `datapath_in` = 0xFFFF.
- ADD: after MOV R0,#7 and MOV R1,#2, run 0xA148 (ADD R2,R1,R0,LSL#1) → control sequence is GET_A (`readnum` = 1), GET_B (`readnum` = 0), EXEC (`shift` = 01, `ALUop` = 00), WR_REG (`writenum` = 2). Datapath R2 = 16; total 6 edges.
- CMP: run 0xA800 (CMP R0,R0) → `loads` = 1 in EXEC, `write` is never 1, `w` after 5 edges; datapath `Z_out` = 1.
- MOV reg and MVN:
  - 0xC040 (MOV R2,R0) → `asel` = 1 in EXEC, no GET_A state.
  - 0xB860 (MVN R3,R0) → `ALUop` = 11, `writenum` = 3.
- Illegal and reset mid-instruction:
  - 0xE000 → `w` returns after 2 edges with no `write`.
  - Assert `reset` during GET_B of an ADD → WAIT immediately; `write` is never asserted.
